// File: rtl/inst_dispatch_queue.sv
// ----------------------------------------------------------------------------
// inst_dispatch_queue
//
// Instruction buffer between the issuing front end and N_CH compute channels.
// Instructions leave in program order. The head is offered to one target
// channel at a time, and the target rotates round-robin over enabled channels.
// Provides an almost-full flag, an empty flag, an occupancy count and a
// synchronous flush.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : synchronous active-high reset
//   inst_i       : incoming instruction
//   inst_valid_i : inst_i valid
//   inst_ready_o : queue can accept (registered state only)
//   flush_i      : discard all queued instructions on the next edge
//   ch_en_i      : per-channel enable mask
//   ch_inst_o    : head instruction, shared by all channels
//   ch_valid_o   : one-hot or zero, head offered to that channel
//   ch_ready_i   : per-channel accept
//   count_o      : occupied entries, 0..DEPTH
//   afull_o      : count >= AFULL_TH
//   empty_o      : count == 0
// ----------------------------------------------------------------------------
module inst_dispatch_queue #(
   parameter int INST_W   = 32,
   parameter int DEPTH    = 8,
   parameter int N_CH     = 2,
   parameter int AFULL_TH = DEPTH - 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [INST_W-1:0]          inst_i,
   input  logic                       inst_valid_i,
   output logic                       inst_ready_o,
   input  logic                       flush_i,
   input  logic [N_CH-1:0]            ch_en_i,
   output logic [INST_W-1:0]          ch_inst_o,
   output logic [N_CH-1:0]            ch_valid_o,
   input  logic [N_CH-1:0]            ch_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       afull_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   // Next enabled channel strictly after cur, searching cyclically.
   // Returns cur unchanged when no other channel is enabled.
   function automatic logic [RR_W-1:0] next_rr(input logic [RR_W-1:0] cur,
                                               input logic [N_CH-1:0] en);
      logic [RR_W-1:0] res;
      logic [N_CH-1:0] shifted;
      logic            found;
      int              idx;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i < N_CH; i++) begin
         idx     = (int'(cur) + i) % N_CH;
         shifted = en >> idx;
         if (!found && shifted[0]) begin
            res   = RR_W'(idx);
            found = 1'b1;
         end else begin
            res   = res;
         end
      end
      return res;
   endfunction

   logic [INST_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic [RR_W-1:0]   rr_q,     rr_d;
   logic              push_s;
   logic              pop_s;
   logic              offer_s;

   // Handshake decode and output offer, all from registered state plus inputs.
   always_comb begin
      inst_ready_o       = !rst_i && (count_q < CNT_W'(DEPTH));
      empty_o            = (count_q == CNT_W'(0));
      afull_o            = (count_q >= CNT_W'(AFULL_TH));
      count_o            = count_q;
      ch_inst_o          = mem_q[rd_ptr_q];
      offer_s            = !empty_o && ch_en_i[rr_q];
      ch_valid_o         = '0;
      ch_valid_o[rr_q]   = offer_s;
      pop_s              = offer_s && ch_ready_i[rr_q];
      push_s             = inst_valid_i && inst_ready_o;
   end

   // Next-state for pointers, count and round-robin target; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rr_d     = rr_q;
      if (flush_i) begin
         // rr_q is deliberately retained across a flush
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         count_d  = CNT_W'(0);
         rr_d     = rr_q;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // Advance after a pop, or skip away from a disabled target
         if (pop_s || !ch_en_i[rr_q]) begin
            rr_d = next_rr(rr_q, ch_en_i);
         end else begin
            rr_d = rr_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= CNT_W'(0);
         rr_q     <= RR_W'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rr_q     <= rr_d;
      end
   end

   // Storage array; a push in a flush cycle is not written.
   always_ff @(posedge clk_i) begin
      if (push_s && !flush_i) begin
         mem_q[wr_ptr_q] <= inst_i;
      end
   end

endmodule

// File: tb/tb_inst_dispatch_queue.sv
module tb_inst_dispatch_queue;

   localparam int INST_W = 32;
   localparam int DEPTH  = 8;
   localparam int N_CH   = 4;
   localparam int AFULL  = DEPTH - 2;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic [INST_W-1:0] inst_i = '0;
   logic              inst_valid_i = 1'b0;
   logic              inst_ready_o;
   logic              flush_i = 1'b0;
   logic [N_CH-1:0]   ch_en_i = '0;
   logic [INST_W-1:0] ch_inst_o;
   logic [N_CH-1:0]   ch_valid_o;
   logic [N_CH-1:0]   ch_ready_i = '0;
   logic [CNT_W-1:0]  count_o;
   logic              afull_o;
   logic              empty_o;

   int checks = 0;
   int errors = 0;

   // reference model: program-order queue plus the current target channel
   logic [INST_W-1:0] mq[$];
   int                mrr = 0;
   // handshakes observed on the DUT outputs
   int                lch[$];
   logic [INST_W-1:0] ldat[$];

   inst_dispatch_queue #(.INST_W(INST_W), .DEPTH(DEPTH), .N_CH(N_CH), .AFULL_TH(AFULL)) dut (
      .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
      .inst_ready_o(inst_ready_o), .flush_i(flush_i), .ch_en_i(ch_en_i),
      .ch_inst_o(ch_inst_o), .ch_valid_o(ch_valid_o), .ch_ready_i(ch_ready_i),
      .count_o(count_o), .afull_o(afull_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int next_en(input int cur, input logic [N_CH-1:0] en);
      for (int k = 1; k < N_CH; k++) begin
         if (en[(cur + k) % N_CH]) return (cur + k) % N_CH;
      end
      return cur;
   endfunction

   task automatic check_outputs();
      logic [N_CH-1:0] exp_valid;
      logic [N_CH-1:0] hs;
      exp_valid = '0;
      if (mq.size() > 0 && ch_en_i[mrr]) exp_valid[mrr] = 1'b1;
      chk("ready", inst_ready_o, (!rst_i && mq.size() < DEPTH));
      chk("count", count_o, mq.size());
      chk("empty", empty_o, (mq.size() == 0));
      chk("afull", afull_o, (mq.size() >= AFULL));
      chk("valid", ch_valid_o, exp_valid);
      if (exp_valid != '0) chk("inst", ch_inst_o, mq[0]);
      hs = ch_valid_o & ch_ready_i;
      if (!rst_i && !flush_i && hs != '0) begin
         for (int k = 0; k < N_CH; k++) begin
            if (hs[k]) begin
               lch.push_back(k);
               ldat.push_back(ch_inst_o);
            end
         end
      end
   endtask

   task automatic model_step();
      logic pop, push;
      logic [INST_W-1:0] tmp;
      if (rst_i) begin
         mq.delete();
         mrr = 0;
      end else if (flush_i) begin
         mq.delete();
      end else begin
         pop  = mq.size() > 0 && ch_en_i[mrr] && ch_ready_i[mrr];
         push = inst_valid_i && mq.size() < DEPTH;
         if (pop) tmp = mq.pop_front();
         if (push) mq.push_back(inst_i);
         if (pop || !ch_en_i[mrr]) mrr = next_en(mrr, ch_en_i);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [INST_W-1:0] d);
      inst_valid_i = 1'b1;
      inst_i = d;
      tick();
      inst_valid_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && mq.size() > 0; i++) tick();
      chk(tag, count_o, 0);
   endtask

   initial begin
      // ---- reset ----
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ch_en_i = 4'b0011;
      tick();
      rst_i = 1'b0;
      #1;
      chk("rst_ready", inst_ready_o, 1);
      chk("rst_empty", empty_o, 1);
      chk("rst_afull", afull_o, 0);
      chk("rst_valid", ch_valid_o, 0);
      chk("rst_count", count_o, 0);

      // ---- fill then drain on two channels ----
      ch_ready_i = 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
         push_one(32'h10 + i);
         if (i + 1 == AFULL) chk("afull_at_th", afull_o, 1);
         if (i + 2 == AFULL) chk("afull_below_th", afull_o, 0);
      end
      chk("full_count", count_o, DEPTH);
      chk("full_ready", inst_ready_o, 0);
      // full with simultaneous pop: push rejected
      ch_ready_i = 4'b0011;
      push_one(32'h20);
      chk("full_pop_count", count_o, DEPTH - 1);
      ch_ready_i = 4'b0000;
      push_one(32'h20);
      chk("full_repush_count", count_o, DEPTH);
      ch_ready_i = 4'b0011;
      drain("fd_drain");
      chk("fd_empty", empty_o, 1);
      chk("fd_n", lch.size(), 9);
      for (int i = 0; i < 9 && i < lch.size(); i++) begin
         chk("fd_ch", lch[i], i % 2);
         chk("fd_dat", ldat[i], (i < 8) ? 32'h10 + i : 32'h20);
      end

      // ---- streaming across pointer wrap ----
      lch.delete(); ldat.delete();
      for (int i = 0; i < 20; i++) begin
         push_one(32'h100 + i);
         if (i == 0) chk("stream_first_offer", (ch_valid_o != '0), 1);
         chk("stream_cnt_le1", (count_o <= 1), 1);
      end
      drain("stream_drain");
      chk("stream_n", lch.size(), 20);
      for (int i = 0; i < 20 && i < lch.size(); i++) begin
         chk("stream_dat", ldat[i], 32'h100 + i);
         if (i > 0) chk("stream_alt", (lch[i] != lch[i-1]), 1);
      end

      // ---- channel masking ----
      lch.delete(); ldat.delete();
      ch_en_i = 4'b1010;
      ch_ready_i = 4'b0000;
      for (int i = 0; i < 4; i++) push_one(32'h200 + i);
      ch_ready_i = 4'b1010;
      drain("mask_drain");
      chk("mask_n", lch.size(), 4);
      for (int i = 0; i < 4 && i < lch.size(); i++) begin
         chk("mask_ch", lch[i], (i % 2 == 0) ? 1 : 3);
         chk("mask_dat", ldat[i], 32'h200 + i);
      end
      ch_ready_i = 4'b0000;
      push_one(32'h300);
      chk("dis_offer_ch1", ch_valid_o, 4'b0010);
      ch_en_i = 4'b1000;
      #1;
      chk("dis_drop", ch_valid_o, 4'b0000);
      tick();
      chk("dis_reoffer_ch3", ch_valid_o, 4'b1000);
      chk("dis_reoffer_inst", ch_inst_o, 32'h300);
      ch_ready_i = 4'b1000;
      drain("dis_drain");

      // ---- flush with concurrent push and pop ----
      lch.delete(); ldat.delete();
      ch_en_i = 4'b1111;
      ch_ready_i = 4'b0000;
      for (int i = 0; i < 5; i++) push_one(32'h400 + i);
      chk("pre_flush_count", count_o, 5);
      flush_i = 1'b1;
      ch_ready_i = 4'b1111;
      push_one(32'h4FF);
      flush_i = 1'b0;
      ch_ready_i = 4'b0000;
      #1;
      chk("flush_count", count_o, 0);
      chk("flush_empty", empty_o, 1);
      chk("flush_valid", ch_valid_o, 0);
      chk("flush_no_hs", lch.size(), 0);
      for (int i = 0; i < 3; i++) push_one(32'h500 + i);
      ch_ready_i = 4'b1111;
      drain("flush_drain");
      chk("flush_n", lch.size(), 3);
      for (int i = 0; i < 3 && i < lch.size(); i++) begin
         chk("flush_rr_ch", lch[i], (3 + i) % 4);
         chk("flush_dat", ldat[i], 32'h500 + i);
      end

      // ---- reset mid-stream ----
      ch_ready_i = 4'b0000;
      for (int i = 0; i < 3; i++) push_one(32'h600 + i);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("mrst_count", count_o, 0);
      chk("mrst_valid", ch_valid_o, 0);
      chk("mrst_empty", empty_o, 1);
      chk("mrst_ready", inst_ready_o, 1);
      push_one(32'h700);
      chk("mrst_rr0", ch_valid_o, 4'b0001);
      chk("mrst_inst", ch_inst_o, 32'h700);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 600; i++) begin
         inst_valid_i = ($urandom_range(0, 3) != 0);
         inst_i       = $urandom;
         ch_ready_i   = 4'($urandom);
         ch_en_i      = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom);
         flush_i      = ($urandom_range(0, 47) == 0);
         rst_i        = ($urandom_range(0, 199) == 0);
         tick();
      end
      inst_valid_i = 1'b0;
      flush_i      = 1'b0;
      rst_i        = 1'b0;
      ch_en_i      = 4'b1111;
      ch_ready_i   = 4'b1111;
      drain("rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
